// File: rtl/rtc_gen_pkg.sv
// Shared register map, CTRL bit positions and DIV field bounds for the
// real-time clock generator.
package rtc_gen_pkg;

    typedef enum logic [1:0] {
        RegCtrl  = 2'd0,
        RegDiv   = 2'd1,
        RegTicks = 2'd2,
        RegCount = 2'd3
    } reg_e;

    localparam int unsigned CtrlEnBit  = 0;
    localparam int unsigned CtrlClrBit = 1;

    localparam int unsigned IntLsb  = 0;
    localparam int unsigned IntMsb  = 15;
    localparam int unsigned FracLsb = 16;
    localparam int unsigned FracMsb = 31;

    localparam int unsigned FieldW = 16;

    // INT=0 behaves as INT=1.
    function automatic logic [FieldW-1:0] max1(input logic [FieldW-1:0] v);
        return (v == '0) ? FieldW'(1) : v;
    endfunction

endpackage

// File: rtl/rtc_gen_if.sv
// Simple valid/ready register bus used to program the RTC generator.
interface rtc_gen_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/rtc_gen_div.sv
// Fractional half-period divider: COUNT/ACC/rt_clk datapath plus tick counter.
module rtc_gen_div
    import rtc_gen_pkg::*;
#(
    parameter logic [FieldW-1:0] CountRst = 16'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [FieldW-1:0] int_i,
    input  logic [FieldW-1:0] frac_i,
    input  logic [FieldW-1:0] clr_int_i,
    output logic              rt_clk_o,
    output logic              rt_tick_o,
    output logic [FieldW-1:0] count_o,
    output logic [31:0]       ticks_o
);

    // One extra bit so that INT=0xFFFF plus a carry still fits.
    logic [FieldW:0]   count_q, count_d;
    logic [FieldW-1:0] acc_q, acc_d;
    logic              rt_clk_q, rt_clk_d;
    logic              rt_tick_q, rt_tick_d;
    logic [31:0]       ticks_q, ticks_d;
    logic [FieldW:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_i};

    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        rt_clk_d  = rt_clk_q;
        rt_tick_d = 1'b0;
        ticks_d   = ticks_q;
        if (clr_i) begin
            count_d  = {1'b0, max1(clr_int_i)};
            acc_d    = '0;
            rt_clk_d = 1'b0;
            ticks_d  = '0;
        end else if (en_i) begin
            if (count_q <= (FieldW+1)'(1)) begin
                rt_clk_d = ~rt_clk_q;
                acc_d    = acc_sum[FieldW-1:0];
                count_d  = {1'b0, max1(int_i)} + {{FieldW{1'b0}}, acc_sum[FieldW]};
                if (!rt_clk_q) begin
                    rt_tick_d = 1'b1;
                    ticks_d   = ticks_q + 32'd1;
                end
            end else begin
                count_d = count_q - (FieldW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= {1'b0, CountRst};
            acc_q     <= '0;
            rt_clk_q  <= 1'b0;
            rt_tick_q <= 1'b0;
            ticks_q   <= '0;
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            rt_clk_q  <= rt_clk_d;
            rt_tick_q <= rt_tick_d;
            ticks_q   <= ticks_d;
        end
    end

    assign rt_clk_o  = rt_clk_q;
    assign rt_tick_o = rt_tick_q;
    assign count_o   = count_q[FieldW-1:0];
    assign ticks_o   = ticks_q;

endmodule

// File: rtl/rtc_gen.sv
// Real-time clock generator: register decode around the fractional divider.
module rtc_gen
    import rtc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter logic [31:0] DIV_RST = 32'hE10005F5,
    parameter logic        EN_RST  = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    rtc_gen_if.slave bus,
    output logic     rt_clk,
    output logic     rt_tick
);

    logic              en_q, en_d;
    logic [31:0]       div_q, div_d;
    logic              ready_q, ready_d;
    logic              wr_en, ctrl_we, div_we, clr;
    reg_e              sel;
    logic [31:0]       rdata_w;
    logic [FieldW-1:0] count;
    logic [31:0]       ticks;
    logic              unused_addr;

    assign sel         = reg_e'(bus.address[3:2]);
    assign unused_addr = ^bus.address;
    assign wr_en       = bus.valid && (|bus.wstrb);
    assign ctrl_we     = wr_en && (sel == RegCtrl);
    assign div_we      = wr_en && (sel == RegDiv);
    assign clr         = ctrl_we && bus.wdata[CtrlClrBit];

    always_comb begin
        en_d    = en_q;
        div_d   = div_q;
        ready_d = bus.valid;
        if (ctrl_we) en_d = bus.wdata[CtrlEnBit];
        if (div_we)  div_d = bus.wdata[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= EN_RST;
            div_q   <= DIV_RST;
            ready_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            div_q   <= div_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        rdata_w = '0;
        unique case (sel)
            RegCtrl:  rdata_w[CtrlEnBit] = en_q;
            RegDiv:   rdata_w = div_q;
            RegTicks: rdata_w = ticks;
            RegCount: rdata_w[FieldW-1:0] = count;
            default:  rdata_w = '0;
        endcase
    end

    assign bus.rdata = rdata_w;
    assign bus.ready = ready_q;

    // Reload normally uses the live DIV; CLR uses the DIV value as of this edge.
    rtc_gen_div #(
        .CountRst (max1(DIV_RST[IntMsb:IntLsb]))
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_q),
        .clr_i     (clr),
        .int_i     (div_q[IntMsb:IntLsb]),
        .frac_i    (div_q[FracMsb:FracLsb]),
        .clr_int_i (div_d[IntMsb:IntLsb]),
        .rt_clk_o  (rt_clk),
        .rt_tick_o (rt_tick),
        .count_o   (count),
        .ticks_o   (ticks)
    );

endmodule

// File: tb/tb_rtc_gen.sv
// Directed self-checking bench for rtc_gen.
module tb_rtc_gen;

    logic clk;
    logic rst;
    logic rt_clk;
    logic rt_tick;

    int checks;
    int failures;

    int tr_t [0:63];
    int tr_n;
    int tick_n;
    int tick_bad;

    rtc_gen_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    rtc_gen dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rt_clk  (rt_clk),
        .rt_tick (rt_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        bus.valid   = 1'b1;
        bus.address = addr;
        bus.wdata   = data;
        bus.wstrb   = 4'hF;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        bus.valid   = 1'b1;
        bus.address = addr;
        bus.wstrb   = 4'h0;
        #1 data = bus.rdata;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    // Records rt_clk transition times (in cycles from the call) until n_rise rises.
    task automatic watch(input int n_rise, input int max_cyc);
        logic prev;
        logic cur;
        int   rises;
        prev     = rt_clk;
        rises    = 0;
        tr_n     = 0;
        tick_n   = 0;
        tick_bad = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            cur = rt_clk;
            if (cur !== prev) begin
                if (tr_n < 64) tr_t[tr_n] = c;
                tr_n++;
            end
            if (rt_tick === 1'b1) begin
                tick_n++;
                if (!(cur === 1'b1 && prev === 1'b0)) tick_bad++;
            end
            if (cur === 1'b1 && prev === 1'b0) rises++;
            prev = cur;
            if (rises == n_rise) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst         = 1'b0;
        bus.valid   = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rt_clk !== 1'b0 || rt_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs rt_clk=%b rt_tick=%b required 0/0", rt_clk, rt_tick);
        end
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b required 0", bus.ready);
        end
        bus.address = 16'hC;
        #1;
        checks++;
        if (bus.rdata !== 32'h0000_05F5) begin
            failures++;
            $display("FAIL reset_count got=%h required 000005f5", bus.rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.valid   = 1'b1;
        bus.address = 16'h0;
        #1;
        checks++;
        if (bus.ready !== 1'b0 || bus.rdata !== 32'h1) begin
            failures++;
            $display("FAIL reset_ctrl ready=%b rdata=%h required 0/00000001", bus.ready, bus.rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_latency got=%b required 1", bus.ready);
        end
        bus.valid = 1'b0;
        bus_read(16'h4, d);
        checks++;
        if (d !== 32'hE100_05F5) begin
            failures++;
            $display("FAIL reset_div got=%h required e10005f5", d);
        end
        bus_read(16'h8, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_ticks got=%h required 0", d);
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0 || rt_clk !== 1'b0) begin
            failures++;
            $display("FAIL ready_drop ready=%b rt_clk=%b required 0/0", bus.ready, rt_clk);
        end
    endtask

    task automatic test_div3();
        logic [31:0] d;
        int bad;
        bus_write(16'h4, 32'h0000_0003);
        bus_write(16'h0, 32'h0000_0003);
        watch(10, 200);
        checks++;
        if (tr_n !== 19 || tr_t[0] !== 3) begin
            failures++;
            $display("FAIL div3_edges count=%0d first=%0d required 19/3", tr_n, tr_t[0]);
        end
        bad = 0;
        for (int i = 1; i < 19 && i < tr_n; i++) if (tr_t[i] - tr_t[i-1] != 3) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL div3_half_period bad_intervals=%0d required 0", bad);
        end
        checks++;
        if (tick_n !== 10 || tick_bad !== 0) begin
            failures++;
            $display("FAIL div3_ticks pulses=%0d misplaced=%0d required 10/0", tick_n, tick_bad);
        end
        bus_read(16'h8, d);
        checks++;
        if (d !== 32'd10) begin
            failures++;
            $display("FAIL div3_ticks_reg got=%0d required 10", d);
        end
    endtask

    task automatic test_frac();
        int exp_t [0:6];
        exp_t = '{2, 4, 7, 9, 12, 14, 17};
        bus_write(16'h4, 32'h8000_0002);
        bus_write(16'h0, 32'h0000_0003);
        watch(4, 100);
        checks++;
        if (tr_n !== 7 || tick_n !== 4) begin
            failures++;
            $display("FAIL frac_edges count=%0d ticks=%0d required 7/4", tr_n, tick_n);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (tr_t[i] !== exp_t[i]) begin
                failures++;
                $display("FAIL frac_edge_%0d got=%0d required %0d", i, tr_t[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_div0();
        bus_write(16'h4, 32'h0000_0000);
        watch(3, 50);
        checks++;
        if (tr_n !== 6 || tick_n !== 3) begin
            failures++;
            $display("FAIL div0_edges count=%0d ticks=%0d required 6/3", tr_n, tick_n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (tr_t[i] !== i + 1) begin
                failures++;
                $display("FAIL div0_edge_%0d got=%0d required %0d", i, tr_t[i], i + 1);
            end
        end
    endtask

    task automatic test_en_hold();
        logic [31:0] d;
        bus_write(16'h4, 32'h0000_000A);
        bus_write(16'h0, 32'h0000_0003);
        repeat (5) @(negedge clk);
        bus_write(16'h0, 32'h0000_0000);
        bus_read(16'hC, d);
        checks++;
        if (d !== 32'd4) begin
            failures++;
            $display("FAIL en_count_at_stop got=%0d required 4", d);
        end
        watch(1, 20);
        checks++;
        if (tr_n !== 0 || tick_n !== 0) begin
            failures++;
            $display("FAIL en_off_activity edges=%0d ticks=%0d required 0/0", tr_n, tick_n);
        end
        bus_read(16'hC, d);
        checks++;
        if (d !== 32'd4 || rt_clk !== 1'b0) begin
            failures++;
            $display("FAIL en_off_hold count=%0d rt_clk=%b required 4/0", d, rt_clk);
        end
        bus_read(16'h0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL en_ctrl_read got=%h required 0", d);
        end
        bus_write(16'h0, 32'h0000_0001);
        watch(1, 20);
        checks++;
        if (tr_n !== 1 || tr_t[0] !== 4 || tick_n !== 1) begin
            failures++;
            $display("FAIL en_resume edges=%0d at=%0d ticks=%0d required 1/4/1",
                     tr_n, tr_t[0], tick_n);
        end
    endtask

    task automatic test_clr_collision();
        logic [31:0] d;
        bus_read(16'h8, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL clr_pre_ticks got=%0d required 1", d);
        end
        repeat (18) @(negedge clk);
        checks++;
        if (rt_clk !== 1'b0) begin
            failures++;
            $display("FAIL clr_pre_level rt_clk=%b required 0", rt_clk);
        end
        bus_write(16'h0, 32'h0000_0003);
        checks++;
        if (rt_clk !== 1'b0 || rt_tick !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority rt_clk=%b rt_tick=%b required 0/0", rt_clk, rt_tick);
        end
        bus_read(16'hC, d);
        checks++;
        if (d !== 32'd10) begin
            failures++;
            $display("FAIL clr_count got=%0d required 10", d);
        end
        bus_read(16'h8, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL clr_ticks got=%0d required 0", d);
        end
        bus_read(16'h0, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL clr_ctrl_read got=%h required 00000001", d);
        end
    endtask

    task automatic test_ro_write();
        logic [31:0] d;
        bus_write(16'h8, 32'hDEAD_BEEF);
        bus_read(16'h8, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL ro_ticks got=%h required 0", d);
        end
        bus_write(16'h0, 32'hFFFF_FFFD);
        bus_read(16'h0, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL ctrl_unused_bits got=%h required 00000001", d);
        end
        bus.valid   = 1'b1;
        bus.address = 16'h4;
        bus.wdata   = 32'h1234_5678;
        bus.wstrb   = 4'h0;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL nostrb_ready got=%b required 1", bus.ready);
        end
        bus.valid = 1'b0;
        bus_read(16'h4, d);
        checks++;
        if (d !== 32'h0000_000A) begin
            failures++;
            $display("FAIL nostrb_div got=%h required 0000000a", d);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        bus_write(16'h4, 32'h0000_0000);
        waited = 0;
        while (rt_clk !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (rt_clk !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre rt_clk=%b required 1", rt_clk);
        end
        #2 rst = 1'b1;
        bus.address = 16'h8;
        #1;
        checks++;
        if (rt_clk !== 1'b0 || rt_tick !== 1'b0 || bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_async rt_clk=%b rt_tick=%b ticks=%h required 0/0/0",
                     rt_clk, rt_tick, bus.rdata);
        end
        bus.address = 16'h4;
        #1;
        checks++;
        if (bus.rdata !== 32'hE100_05F5) begin
            failures++;
            $display("FAIL rstmid_div got=%h required e10005f5", bus.rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        watch(1, 1600);
        checks++;
        if (tr_n !== 1 || tr_t[0] !== 1525) begin
            failures++;
            $display("FAIL rstmid_first_toggle edges=%0d at=%0d required 1/1525", tr_n, tr_t[0]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_div3();
        test_frac();
        test_div0();
        test_en_hold();
        test_clr_collision();
        test_ro_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
